// File: rtl/cmp_result_tracker_if.sv
// cmp_result_tracker_if
//   Bundles the comparator-result sample inputs, the live tally outputs and the
//   snapshot valid/ready handshake of cmp_result_tracker.
//   master : the producer/reader side (drives samples, clear, snap_req, snap_ready)
//   slave  : the tracker itself (drives tallies, run state and snap_* outputs)
// Parameters
//   CNT_W  width of every tally counter
//   RUN_W  width of the run-length counter
interface cmp_result_tracker_if #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
);
    logic             in_valid;
    logic             in_e;
    logic             in_l;
    logic             in_g;
    logic             clear;

    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_flag;
    logic [RUN_W-1:0] run_len;
    logic [1:0]       run_kind;
    logic             streak_alert;

    logic             snap_req;
    logic             snap_valid;
    logic             snap_ready;
    logic [CNT_W-1:0] snap_eq;
    logic [CNT_W-1:0] snap_lt;
    logic [CNT_W-1:0] snap_gt;
    logic [CNT_W-1:0] snap_total;

    modport master (
        output in_valid, in_e, in_l, in_g, clear, snap_req, snap_ready,
        input  eq_cnt, lt_cnt, gt_cnt, total_cnt, err_cnt, err_flag,
               run_len, run_kind, streak_alert,
               snap_valid, snap_eq, snap_lt, snap_gt, snap_total
    );

    modport slave (
        input  in_valid, in_e, in_l, in_g, clear, snap_req, snap_ready,
        output eq_cnt, lt_cnt, gt_cnt, total_cnt, err_cnt, err_flag,
               run_len, run_kind, streak_alert,
               snap_valid, snap_eq, snap_lt, snap_gt, snap_total
    );
endinterface

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
//   Consumes one E/L/G comparator result per clock, keeps saturating tallies of
//   legal outcomes, counts malformed (non-one-hot) flag vectors, tracks the run
//   of identical outcomes and lets a reader freeze a snapshot of the tallies
//   through a valid/ready handshake while counting continues.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cmp_result_tracker_if.slave (samples, clear, tallies, run state, snapshot)
// Snapshot FSM
//   state | meaning
//   IDLE  | no snapshot held; snap_req captures the current tallies
//   HOLD  | snap_* frozen, snap_valid=1; waits for snap_ready
module cmp_result_tracker #(
    parameter int CNT_W      = 8,
    parameter int RUN_W      = 4,
    parameter int RUN_THRESH = 4
) (
    input logic                 clk,
    input logic                 rst,
    cmp_result_tracker_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_t;

    localparam logic [RUN_W-1:0] RUN_MAX     = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_PRE_HIT = RUN_W'(RUN_THRESH - 1);

    logic [CNT_W-1:0] eq_q, lt_q, gt_q, total_q, err_q;
    logic             err_flag_q;
    logic [RUN_W-1:0] run_len_q;
    logic [1:0]       run_kind_q;
    logic             alert_q;

    snap_state_t      snap_state;
    logic             snap_valid_q;
    logic [CNT_W-1:0] snap_eq_q, snap_lt_q, snap_gt_q, snap_total_q;

    logic             legal;
    logic [1:0]       kind;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // One-hot test: odd parity excludes 000/011/101/110, the AND term excludes 111.
    always_comb begin
        legal = (bus.in_e ^ bus.in_l ^ bus.in_g) & ~(bus.in_e & bus.in_l & bus.in_g);
        kind  = 2'b00;
        if (bus.in_e)
            kind = 2'b01;
        else if (bus.in_l)
            kind = 2'b10;
        else if (bus.in_g)
            kind = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q       <= '0;
            lt_q       <= '0;
            gt_q       <= '0;
            total_q    <= '0;
            err_q      <= '0;
            err_flag_q <= 1'b0;
            run_len_q  <= '0;
            run_kind_q <= 2'b00;
            alert_q    <= 1'b0;
        end else begin
            alert_q <= 1'b0;
            if (bus.clear) begin
                eq_q       <= '0;
                lt_q       <= '0;
                gt_q       <= '0;
                total_q    <= '0;
                err_q      <= '0;
                err_flag_q <= 1'b0;
                run_len_q  <= '0;
                run_kind_q <= 2'b00;
            end else if (bus.in_valid) begin
                if (legal) begin
                    total_q <= sat_inc(total_q);
                    case (kind)
                        2'b01:   eq_q <= sat_inc(eq_q);
                        2'b10:   lt_q <= sat_inc(lt_q);
                        default: gt_q <= sat_inc(gt_q);
                    endcase
                    // run_kind is 00 whenever no run is active, so a legal kind
                    // can only match an existing run of length >= 1.
                    if (kind == run_kind_q) begin
                        if (run_len_q != RUN_MAX) begin
                            run_len_q <= run_len_q + RUN_W'(1);
                            alert_q   <= (run_len_q == RUN_PRE_HIT);
                        end
                    end else begin
                        run_len_q  <= RUN_W'(1);
                        run_kind_q <= kind;
                        alert_q    <= (RUN_THRESH == 1);
                    end
                end else begin
                    err_q      <= sat_inc(err_q);
                    err_flag_q <= 1'b1;
                    run_len_q  <= '0;
                    run_kind_q <= 2'b00;
                end
            end
        end
    end

    // Capture reads the tally registers before this edge's update, so the
    // snapshot equals what was visible on the outputs in the request cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_state   <= IDLE;
            snap_valid_q <= 1'b0;
            snap_eq_q    <= '0;
            snap_lt_q    <= '0;
            snap_gt_q    <= '0;
            snap_total_q <= '0;
        end else begin
            case (snap_state)
                IDLE: begin
                    if (bus.snap_req) begin
                        snap_eq_q    <= eq_q;
                        snap_lt_q    <= lt_q;
                        snap_gt_q    <= gt_q;
                        snap_total_q <= total_q;
                        snap_state   <= HOLD;
                        snap_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (snap_valid_q && bus.snap_ready) begin
                        snap_state   <= IDLE;
                        snap_valid_q <= 1'b0;
                    end
                end
                default: begin
                    snap_state   <= IDLE;
                    snap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.eq_cnt       = eq_q;
    assign bus.lt_cnt       = lt_q;
    assign bus.gt_cnt       = gt_q;
    assign bus.total_cnt    = total_q;
    assign bus.err_cnt      = err_q;
    assign bus.err_flag     = err_flag_q;
    assign bus.run_len      = run_len_q;
    assign bus.run_kind     = run_kind_q;
    assign bus.streak_alert = alert_q;
    assign bus.snap_valid   = snap_valid_q;
    assign bus.snap_eq      = snap_eq_q;
    assign bus.snap_lt      = snap_lt_q;
    assign bus.snap_gt      = snap_gt_q;
    assign bus.snap_total   = snap_total_q;

endmodule
